// File: rtl/trojan.sv
// First-word-fall-through FIFO with a hidden three-word trigger sequence.
// When the sequence completes, the FIFO is flushed and the input is blocked for BLOCK cycles.
module trojan #(
  parameter int            DW    = 16,
  parameter int            DEPTH = 4,
  parameter logic [DW-1:0] TRIG0 = 16'hAAAA,
  parameter logic [DW-1:0] TRIG1 = 16'hBBBB,
  parameter logic [DW-1:0] TRIG2 = 16'hCCCC,
  parameter int            BLOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] dout_o,
  output logic          valid_o,
  input  logic          ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BLOCK + 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] BLOCK_LD  = BW'(BLOCK);
  localparam logic [BW-1:0] BLOCK_ONE = BW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_S1    = 2'd1,
    ST_S2    = 2'd2,
    ST_BLOCK = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] blk_cnt, blk_cnt_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] mem [DEPTH];

  logic blocking, push, pop, trigger;

  assign blocking = (state == ST_BLOCK);
  assign ready_o  = !blocking && (count < FULL);
  assign valid_o  = !blocking && (count != '0);
  assign dout_o   = valid_o ? mem[rd_ptr] : '0;
  assign push     = valid_i && ready_o;
  assign pop      = valid_o && ready_i;
  assign trigger  = push && (state == ST_S2) && (din_i == TRIG2);

  // Trigger detector only moves on accepted pushes; BLOCK counts down on its own.
  always_comb begin
    state_nxt   = state;
    blk_cnt_nxt = blk_cnt;
    case (state)
      ST_IDLE: begin
        if (push && din_i == TRIG0) state_nxt = ST_S1;
      end
      ST_S1: begin
        if (push) begin
          if (din_i == TRIG1)      state_nxt = ST_S2;
          else if (din_i == TRIG0) state_nxt = ST_S1;
          else                     state_nxt = ST_IDLE;
        end
      end
      ST_S2: begin
        if (push) begin
          if (din_i == TRIG2) begin
            state_nxt   = ST_BLOCK;
            blk_cnt_nxt = BLOCK_LD;
          end else if (din_i == TRIG0) begin
            state_nxt = ST_S1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_BLOCK: begin
        blk_cnt_nxt = blk_cnt - BLOCK_ONE;
        if (blk_cnt == BLOCK_ONE) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      blk_cnt <= '0;
    end else begin
      state   <= state_nxt;
      blk_cnt <= blk_cnt_nxt;
    end
  end

  // A pop coinciding with the trigger still delivers its word; the flush wipes everything after it.
  always_ff @(posedge clk) begin
    if (rst || trigger) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !trigger) mem[wr_ptr] <= din_i;
  end

endmodule

// File: tb/tb_trojan.sv
// Scoreboard bench for trojan: a queue-based reference model tracks FIFO contents and trigger progress.
module tb_trojan;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int BLOCK = 4;
  localparam logic [DW-1:0] T0 = 16'hAAAA;
  localparam logic [DW-1:0] T1 = 16'hBBBB;
  localparam logic [DW-1:0] T2 = 16'hCCCC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DW-1:0] din_i = '0;
  logic          ready_o, valid_o;
  logic [DW-1:0] dout_o;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents, length of matched trigger prefix, remaining blocked cycles.
  logic [DW-1:0] sb[$];
  int  phase = 0;
  int  blk   = 0;
  bit  armed = 1'b0;

  always #5 clk = ~clk;

  trojan #(.DW(DW), .DEPTH(DEPTH), .TRIG0(T0), .TRIG1(T1), .TRIG2(T2), .BLOCK(BLOCK)) dut (
    .clk    (clk),
    .rst    (rst),
    .din_i  (din_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .dout_o (dout_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [DW-1:0] d, input logic rdy);
    rst     = r;
    valid_i = v;
    din_i   = d;
    ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  // Model update at each rising edge, from the inputs presented before it.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        sb.delete();
        phase = 0;
        blk   = 0;
        armed = 1'b1;
      end else if (blk > 0) begin
        blk--;
      end else begin
        bit acc;
        acc = valid_i && (sb.size() < DEPTH);
        if (ready_i && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
          if (phase == 2 && din_i == T2) begin
            sb.delete();
            blk   = BLOCK;
            phase = 0;
          end else begin
            sb.push_back(din_i);
            if (phase == 1 && din_i == T1) phase = 2;
            else if (din_i == T0)          phase = 1;
            else                           phase = 0;
          end
        end
      end
    end
  end

  // Monitor: checks handshake outputs and the head word presented to downstream.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        logic          e_ready, e_valid;
        logic [DW-1:0] e_dout;
        e_ready = (blk == 0) && (sb.size() < DEPTH);
        e_valid = (blk == 0) && (sb.size() > 0);
        e_dout  = e_valid ? sb[0] : '0;
        chk("ready_o", {15'd0, ready_o}, {15'd0, e_ready});
        chk("valid_o", {15'd0, valid_o}, {15'd0, e_valid});
        chk("dout_o", dout_o, e_dout);
      end
    end
  end

  initial begin
    // Reset with all inputs low
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);

    // Single word through an always-ready sink
    drive(1'b0, 1'b1, 16'h1111, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);

    // Fill, refuse, drain in order
    for (int i = 1; i <= 5; i++) drive(1'b0, 1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 6; i++)  drive(1'b0, 1'b0, '0, 1'b1);

    // Trigger with idle gaps, then a word after the blocking window
    drive(1'b0, 1'b1, T0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, T1, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, T2, 1'b1);
    for (int i = 0; i < BLOCK; i++) drive(1'b0, 1'b1, 16'h5555, 1'b1);
    drive(1'b0, 1'b1, 16'hDDDD, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);

    // Broken sequence must not trigger
    drive(1'b0, 1'b1, T0, 1'b1);
    drive(1'b0, 1'b1, T1, 1'b1);
    drive(1'b0, 1'b1, 16'h1234, 1'b1);
    drive(1'b0, 1'b1, T2, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, 1'b1);

    // Reset in the middle of the blocking window
    drive(1'b0, 1'b1, T0, 1'b0);
    drive(1'b0, 1'b1, T1, 1'b0);
    drive(1'b0, 1'b1, T2, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 16'hEEEE, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic biased toward trigger words
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = T0;
        1:       d = T1;
        2:       d = T2;
        default: d = DW'($urandom);
      endcase
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), d,
            ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
